fetch_ctrl: RTL

//  Instruction-fetch sequencer between the PC, a variable-latency instruction memory and the decode stage.

---
 rtl/fetch_ctrl_if.sv | 36 +++
 rtl/fetch_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// Fetch-stage bus: instruction-memory req/ack, redirect inputs and the valid/ready decode output.
// master = fetch_ctrl, slave = memory/decode/branch environment.
interface fetch_ctrl_if #(
  parameter int AW = 8
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  logic          br_valid;
  logic [AW-1:0] br_target;
  logic          exc_valid;

  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_ir;
  logic [AW-1:0] if_pc;
  logic [AW-1:0] if_npc;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  br_valid, br_target, exc_valid,
    output if_valid, if_ir, if_pc, if_npc,
    input  if_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output br_valid, br_target, exc_valid,
    input  if_valid, if_ir, if_pc, if_npc,
    output if_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: one outstanding imem request, {ir,pc,npc} to decode one cycle after ack,
// output held under if_ready backpressure (1-entry skid behind it); redirects flush and drain wrong-path fetches.
module fetch_ctrl #(
  parameter int            AW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0,
  parameter logic [AW-1:0] EXC_VEC  = 8'hF0
) (
  input  logic         clk,
  input  logic         rst,
  fetch_ctrl_if.master bus
);

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef struct packed {
    logic [31:0]   ir;
    logic [AW-1:0] pc;
    logic [AW-1:0] npc;
  } fetch_t;

  localparam logic [AW-1:0] ONE = 1;

  state_t        state;
  logic [AW-1:0] pc;
  logic [AW-1:0] req_addr;
  logic          pend;
  fetch_t        out_q;
  fetch_t        skid_q;
  logic          out_vld;
  logic          skid_vld;

  logic          redirect;
  logic          xfer;
  logic          req;
  logic          take;
  logic [AW-1:0] addr;
  fetch_t        fetched;

  always_comb begin
    redirect = bus.exc_valid | bus.br_valid;
    xfer     = out_vld & bus.if_ready;
    // Pending request (including a wrong-path one being drained) keeps req high regardless of the output state.
    req      = !rst && (pend || (state == RUN && !skid_vld && (!out_vld || xfer)));
    addr     = pend ? req_addr : pc;
    take     = req && bus.imem_ack && (state == RUN) && !redirect;
    fetched  = '{ir: bus.imem_rdata, pc: addr, npc: addr + ONE};
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = addr;
  assign bus.if_valid  = out_vld;
  assign bus.if_ir     = out_q.ir;
  assign bus.if_pc     = out_q.pc;
  assign bus.if_npc    = out_q.npc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      req_addr <= '0;
      pend     <= 1'b0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      if (req) begin
        pend     <= !bus.imem_ack;
        req_addr <= addr;
      end

      if (redirect) begin
        pc       <= bus.exc_valid ? EXC_VEC : bus.br_target;
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
        // A same-cycle ack is simply discarded; an unanswered request must be drained first.
        state    <= (req && !bus.imem_ack) ? DRAIN : RUN;
      end else begin
        if (state == DRAIN && bus.imem_ack) begin
          state <= RUN;
        end

        if (xfer) begin
          out_vld  <= skid_vld;
          skid_vld <= 1'b0;
          if (skid_vld) begin
            out_q <= skid_q;
          end
        end

        if (take) begin
          pc <= pc + ONE;
          if (!out_vld || xfer) begin
            out_vld <= 1'b1;
            out_q   <= fetched;
          end else begin
            skid_vld <= 1'b1;
            skid_q   <= fetched;
          end
        end
      end
    end
  end

  // The skid only ever sits behind a full output and never coexists with an outstanding request.
  assert property (@(posedge clk) disable iff (rst) skid_vld |-> out_vld);
  assert property (@(posedge clk) disable iff (rst) skid_vld |-> !pend);

endmodule
